// File: rtl/hash_collector_pkg.sv
// Shared types and constants for the hash_collector digest assembler.
package hash_collector_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_e;

   localparam logic [7:0] CRC8_POLY = 8'h07;
   localparam logic [7:0] CRC8_INIT = 8'h00;

endpackage

// File: rtl/hash_collector_if.sv
// Hash byte stream from the BLAKE2 top: one byte per cycle qualified by hash_v.
interface hash_collector_if;
   logic [7:0] hash;
   logic       hash_v;

   modport master (output hash, output hash_v);
   modport slave  (input  hash, input  hash_v);
endinterface

// File: rtl/hash_collector_crc8_byte.sv
// Combinational CRC-8 step: folds one byte into a running CRC, MSB first.
module crc8_byte
   import hash_collector_pkg::*;
(
   input  logic [7:0] crc_i,
   input  logic [7:0] data_i,
   output logic [7:0] crc_o
);

   logic [7:0] c;

   always_comb begin
      c = crc_i ^ data_i;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
      end
      crc_o = c;
   end

endmodule

// File: rtl/hash_collector.sv
// Assembles BLAKE2 digest bytes into a register buffer, counts digests, flags overrun/gap errors.
// Optional CRC-8 over each captured digest when HASH_CRC_EN is defined.
module hash_collector
   import hash_collector_pkg::*;
#(
   parameter int HASH_BYTES = 32,
   parameter int GAP_MAX    = 15,
   parameter int CNT_W      = 8,
   parameter int SEL_W      = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   hash_collector_if.slave    in_if,
   input  logic               clear_i,
   input  logic [SEL_W-1:0]   rd_sel_i,
   output logic [7:0]         rd_data_o,
   output logic               buf_valid_o,
   output logic               done_o,
   output logic               busy_o,
   output logic [CNT_W-1:0]   hash_cnt_o,
   output logic               overrun_o,
   output logic               err_gap_o,
   output logic [7:0]         crc_o
);

   localparam int IDX_W = SEL_W;
   localparam int GAP_W = $clog2(GAP_MAX + 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [7:0]         buf_q [HASH_BYTES];
   logic [7:0]         buf_d [HASH_BYTES];
   logic               done_q, done_d;
   logic               buf_valid_q, buf_valid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               overrun_q, overrun_d;
   logic               err_gap_q, err_gap_d;
   logic [7:0]         rd_data_q, rd_data_d;
   logic               capture, complete;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      gap_d       = gap_q;
      buf_d       = buf_q;
      done_d      = 1'b0;
      buf_valid_d = buf_valid_q;
      cnt_d       = cnt_q;
      overrun_d   = overrun_q;
      err_gap_d   = err_gap_q;
      capture     = in_if.hash_v;
      complete    = 1'b0;

      // Clear first so a same-cycle completion or gap event overrides it.
      if (clear_i) begin
         buf_valid_d = 1'b0;
         overrun_d   = 1'b0;
         err_gap_d   = 1'b0;
      end

      if (capture) begin
         buf_d[idx_q] = in_if.hash;
         gap_d        = '0;
         if (idx_q == IDX_W'(HASH_BYTES - 1)) begin
            complete = 1'b1;
            idx_d    = '0;
            state_d  = IDLE;
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = RECV;
         end
      end else if (state_q == RECV) begin
         if (gap_q == GAP_W'(GAP_MAX)) begin
            err_gap_d = 1'b1;
            idx_d     = '0;
            gap_d     = '0;
            state_d   = IDLE;
         end else begin
            gap_d = gap_q + 1'b1;
         end
      end

      if (complete) begin
         done_d      = 1'b1;
         buf_valid_d = 1'b1;
         cnt_d       = cnt_q + 1'b1;
         if (buf_valid_q) overrun_d = 1'b1;
      end

      rd_data_d = (int'(rd_sel_i) < HASH_BYTES) ? buf_q[rd_sel_i] : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         gap_q       <= '0;
         done_q      <= 1'b0;
         buf_valid_q <= 1'b0;
         cnt_q       <= '0;
         overrun_q   <= 1'b0;
         err_gap_q   <= 1'b0;
         rd_data_q   <= 8'h00;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         done_q      <= done_d;
         buf_valid_q <= buf_valid_d;
         cnt_q       <= cnt_d;
         overrun_q   <= overrun_d;
         err_gap_q   <= err_gap_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Digest storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

`ifdef HASH_CRC_EN
   logic [7:0] crc_run_q, crc_run_d;
   logic [7:0] crc_q, crc_d;
   logic [7:0] crc_seed, crc_nxt;

   assign crc_seed = (idx_q == '0) ? CRC8_INIT : crc_run_q;

   crc8_byte u_crc8 (
      .crc_i  (crc_seed),
      .data_i (in_if.hash),
      .crc_o  (crc_nxt)
   );

   always_comb begin
      crc_run_d = crc_run_q;
      crc_d     = crc_q;
      if (capture)  crc_run_d = crc_nxt;
      if (complete) crc_d     = crc_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_run_q <= CRC8_INIT;
         crc_q     <= 8'h00;
      end else begin
         crc_run_q <= crc_run_d;
         crc_q     <= crc_d;
      end
   end

   assign crc_o = crc_q;
`else
   assign crc_o = 8'h00;
`endif

   assign rd_data_o   = rd_data_q;
   assign buf_valid_o = buf_valid_q;
   assign done_o      = done_q;
   assign busy_o      = (state_q == RECV);
   assign hash_cnt_o  = cnt_q;
   assign overrun_o   = overrun_q;
   assign err_gap_o   = err_gap_q;

endmodule

// File: tb/tb_hash_collector.sv
// Directed bench for hash_collector: a 32-byte instance plus a 1-byte instance for the CRC/degenerate case.
module tb_hash_collector;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 32-byte digest instance
   hash_collector_if u_if0 ();
   logic       clear0  = 1'b0;
   logic [4:0] rd_sel0 = '0;
   logic [7:0] rd_data0, crc0, cnt0;
   logic       buf_valid0, done0, busy0, overrun0, err_gap0;

   hash_collector #(.HASH_BYTES(32), .GAP_MAX(15), .CNT_W(8)) u_dut0 (
      .clk(clk), .rst(rst), .in_if(u_if0.slave), .clear_i(clear0), .rd_sel_i(rd_sel0),
      .rd_data_o(rd_data0), .buf_valid_o(buf_valid0), .done_o(done0), .busy_o(busy0),
      .hash_cnt_o(cnt0), .overrun_o(overrun0), .err_gap_o(err_gap0), .crc_o(crc0)
   );

   // 1-byte digest instance
   hash_collector_if u_if1 ();
   logic       clear1  = 1'b0;
   logic [0:0] rd_sel1 = '0;
   logic [7:0] rd_data1, crc1, cnt1;
   logic       buf_valid1, done1, busy1, overrun1, err_gap1;

   hash_collector #(.HASH_BYTES(1), .GAP_MAX(15), .CNT_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .in_if(u_if1.slave), .clear_i(clear1), .rd_sel_i(rd_sel1),
      .rd_data_o(rd_data1), .buf_valid_o(buf_valid1), .done_o(done1), .busy_o(busy1),
      .hash_cnt_o(cnt1), .overrun_o(overrun1), .err_gap_o(err_gap1), .crc_o(crc1)
   );

`ifdef HASH_CRC_EN
   localparam logic [7:0] EXP_CRC_01 = 8'h07;
   localparam logic [7:0] EXP_CRC_80 = 8'h89;
`else
   localparam logic [7:0] EXP_CRC_01 = 8'h00;
   localparam logic [7:0] EXP_CRC_80 = 8'h00;
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive n contiguous bytes base, base+1, ...; clear_i optionally on the last byte.
   task automatic send_bytes(input logic [7:0] base, input int n, input bit clr_last, output int dones);
      dones = 0;
      for (int i = 0; i < n; i++) begin
         u_if0.hash_v = 1'b1;
         u_if0.hash   = base + 8'(i);
         clear0       = clr_last && (i == n - 1);
         step();
         if (done0) dones++;
      end
      u_if0.hash_v = 1'b0;
      clear0       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({done0, busy0, buf_valid0, overrun0, err_gap0} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {done0, busy0, buf_valid0, overrun0, err_gap0});
      end
      checks++;
      if (cnt0 !== 8'd0 || rd_data0 !== 8'd0 || crc0 !== 8'd0) begin
         errors++; $display("FAIL reset_data: cnt=%0d rd=%h crc=%h want 0/00/00", cnt0, rd_data0, crc0);
      end
      checks++;
      if ({done1, busy1, buf_valid1, cnt1, crc1} !== 19'b0) begin
         errors++; $display("FAIL reset_dut1: got %h want 0", {done1, busy1, buf_valid1, cnt1, crc1});
      end
   endtask

   task automatic test_full_digest();
      int dn;
      send_bytes(8'h00, 32, 1'b0, dn);
      checks++;
      if (dn !== 1 || done0 !== 1'b1) begin
         errors++; $display("FAIL full_done: pulses=%0d done=%b want 1/1", dn, done0);
      end
      checks++;
      if (buf_valid0 !== 1'b1 || cnt0 !== 8'd1 || busy0 !== 1'b0) begin
         errors++; $display("FAIL full_state: bv=%b cnt=%0d busy=%b want 1/1/0", buf_valid0, cnt0, busy0);
      end
      rd_sel0 = 5'd5;
      step();
      checks++;
      if (done0 !== 1'b0) begin
         errors++; $display("FAIL full_done_pulse: done=%b want 0", done0);
      end
      checks++;
      if (rd_data0 !== 8'h05) begin
         errors++; $display("FAIL full_rd5: got %h want 05", rd_data0);
      end
      rd_sel0 = 5'd31;
      step();
      checks++;
      if (rd_data0 !== 8'h1F) begin
         errors++; $display("FAIL full_rd31: got %h want 1f", rd_data0);
      end
   endtask

   task automatic test_gap_error();
      int dn;
      clear0 = 1'b1; step(); clear0 = 1'b0;
      send_bytes(8'h30, 10, 1'b0, dn);
      checks++;
      if (busy0 !== 1'b1) begin
         errors++; $display("FAIL gap_busy: got %b want 1", busy0);
      end
      idle(15);
      checks++;
      if (err_gap0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++; $display("FAIL gap_15idle: err=%b busy=%b want 0/1", err_gap0, busy0);
      end
      idle(1);
      checks++;
      if (err_gap0 !== 1'b1 || busy0 !== 1'b0 || buf_valid0 !== 1'b0 || cnt0 !== 8'd1) begin
         errors++; $display("FAIL gap_16idle: err=%b busy=%b bv=%b cnt=%0d want 1/0/0/1", err_gap0, busy0, buf_valid0, cnt0);
      end
      send_bytes(8'h40, 32, 1'b0, dn);
      checks++;
      if (dn !== 1 || cnt0 !== 8'd2 || buf_valid0 !== 1'b1 || err_gap0 !== 1'b1) begin
         errors++; $display("FAIL gap_recover: pulses=%0d cnt=%0d bv=%b err=%b want 1/2/1/1", dn, cnt0, buf_valid0, err_gap0);
      end
      rd_sel0 = 5'd0;
      step();
      checks++;
      if (rd_data0 !== 8'h40) begin
         errors++; $display("FAIL gap_rd0: got %h want 40", rd_data0);
      end
   endtask

   task automatic test_back_to_back();
      int dn;
      clear0 = 1'b1; step(); clear0 = 1'b0;
      send_bytes(8'h80, 64, 1'b0, dn);
      checks++;
      if (dn !== 2 || cnt0 !== 8'd4) begin
         errors++; $display("FAIL b2b_count: pulses=%0d cnt=%0d want 2/4", dn, cnt0);
      end
      checks++;
      if (overrun0 !== 1'b1 || buf_valid0 !== 1'b1) begin
         errors++; $display("FAIL b2b_overrun: ovr=%b bv=%b want 1/1", overrun0, buf_valid0);
      end
      rd_sel0 = 5'd3;
      step();
      checks++;
      if (rd_data0 !== 8'hA3) begin
         errors++; $display("FAIL b2b_rd3: got %h want a3", rd_data0);
      end
   endtask

   task automatic test_clear_race();
      int dn;
      clear0 = 1'b1; step(); clear0 = 1'b0;
      checks++;
      if ({buf_valid0, overrun0, err_gap0} !== 3'b000) begin
         errors++; $display("FAIL clr_flags: got %b want 000", {buf_valid0, overrun0, err_gap0});
      end
      send_bytes(8'h60, 32, 1'b1, dn);
      checks++;
      if (buf_valid0 !== 1'b1 || dn !== 1 || overrun0 !== 1'b0) begin
         errors++; $display("FAIL clr_race: bv=%b pulses=%0d ovr=%b want 1/1/0", buf_valid0, dn, overrun0);
      end
      clear0 = 1'b1; step(); clear0 = 1'b0;
      checks++;
      if (buf_valid0 !== 1'b0) begin
         errors++; $display("FAIL clr_after: bv=%b want 0", buf_valid0);
      end
   endtask

   task automatic test_gap_boundary_wrap();
      int dn, total;
      do_reset();
      send_bytes(8'h10, 10, 1'b0, dn);
      idle(15);
      send_bytes(8'h1A, 22, 1'b0, dn);
      checks++;
      if (dn !== 1 || err_gap0 !== 1'b0 || cnt0 !== 8'd1) begin
         errors++; $display("FAIL gap_exact: pulses=%0d err=%b cnt=%0d want 1/0/1", dn, err_gap0, cnt0);
      end
      rd_sel0 = 5'd10;
      step();
      checks++;
      if (rd_data0 !== 8'h1A) begin
         errors++; $display("FAIL gap_exact_rd10: got %h want 1a", rd_data0);
      end
      total = 0;
      for (int d = 0; d < 254; d++) begin
         send_bytes(8'(d), 32, 1'b0, dn);
         total += dn;
      end
      checks++;
      if (cnt0 !== 8'd255 || total !== 254) begin
         errors++; $display("FAIL wrap_255: cnt=%0d pulses=%0d want 255/254", cnt0, total);
      end
      send_bytes(8'hEE, 32, 1'b0, dn);
      checks++;
      if (cnt0 !== 8'd0 || dn !== 1) begin
         errors++; $display("FAIL wrap_0: cnt=%0d pulses=%0d want 0/1", cnt0, dn);
      end
   endtask

   task automatic test_crc();
      u_if1.hash_v = 1'b1; u_if1.hash = 8'h01;
      step();
      u_if1.hash_v = 1'b0;
      checks++;
      if (done1 !== 1'b1 || buf_valid1 !== 1'b1 || cnt1 !== 8'd1 || busy1 !== 1'b0) begin
         errors++; $display("FAIL one_byte: done=%b bv=%b cnt=%0d busy=%b want 1/1/1/0", done1, buf_valid1, cnt1, busy1);
      end
      checks++;
      if (crc1 !== EXP_CRC_01) begin
         errors++; $display("FAIL crc_01: got %h want %h", crc1, EXP_CRC_01);
      end
      rd_sel1 = 1'b0;
      step();
      checks++;
      if (rd_data1 !== 8'h01 || crc1 !== EXP_CRC_01) begin
         errors++; $display("FAIL one_rd0: rd=%h crc=%h want 01/%h", rd_data1, crc1, EXP_CRC_01);
      end
      u_if1.hash_v = 1'b1; u_if1.hash = 8'h80;
      step();
      u_if1.hash_v = 1'b0;
      checks++;
      if (overrun1 !== 1'b1 || cnt1 !== 8'd2 || crc1 !== EXP_CRC_80) begin
         errors++; $display("FAIL crc_80: ovr=%b cnt=%0d crc=%h want 1/2/%h", overrun1, cnt1, crc1, EXP_CRC_80);
      end
      rd_sel1 = 1'b1;
      step();
      checks++;
      if (rd_data1 !== 8'h00) begin
         errors++; $display("FAIL rd_oob: got %h want 00", rd_data1);
      end
   endtask

   initial begin
      u_if0.hash = 8'h00; u_if0.hash_v = 1'b0;
      u_if1.hash = 8'h00; u_if1.hash_v = 1'b0;
      test_reset();
      test_full_digest();
      test_gap_error();
      test_back_to_back();
      test_clear_race();
      test_gap_boundary_wrap();
      test_crc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
